seg7_scan_module: RTL

Three-digit multiplexed 7-segment display driver for the common-anode LED module. It accepts the 12-bit packed BCD value from the BCD counter (`Number_Sig`). Each frame it captures a tear-free snapshot of that value. It then time-multiplexes the three digits onto the shared segment bus with per-digit dead time and optional leading-zero blanking.

---
 rtl/seg7_scan_module_if.sv | 21 ++
 rtl/seg7_scan_module.sv | 119 +++++++++++
 2 files changed

// File: rtl/seg7_scan_module_if.sv
// Signal bundle between the BCD source and the three-digit 7-segment scan driver.
// Data contract: no handshake. Number_Sig/Blank_En are level inputs that the driver
// samples once per frame; SMG_Data/Scan_Sig/Frame_Done are registered outputs.
interface seg7_scan_module_if;
    logic [11:0] Number_Sig;
    logic        Blank_En;
    logic [7:0]  SMG_Data;
    logic [2:0]  Scan_Sig;
    logic        Frame_Done;
    logic [1:0]  Scan_State;

    modport master (
        output Number_Sig, Blank_En,
        input  SMG_Data, Scan_Sig, Frame_Done, Scan_State
    );

    modport slave (
        input  Number_Sig, Blank_En,
        output SMG_Data, Scan_Sig, Frame_Done, Scan_State
    );
endinterface

// File: rtl/seg7_scan_module.sv
// Three-digit multiplexed common-anode 7-segment driver with a per-frame tear-free
// snapshot, per-slot dead time and optional leading-zero blanking.
module seg7_scan_module #(
    parameter logic [15:0] T1MS = 16'd49_999,
    parameter logic [15:0] DEAD = 16'd2_499
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    seg7_scan_module_if.slave          bus
);
    typedef enum logic [1:0] {
        DIG0 = 2'b00,
        DIG1 = 2'b01,
        DIG2 = 2'b10
    } state_t;

    state_t      state;
    logic [15:0] C1;
    logic [11:0] rNum;
    logic        rBlank;
    logic [7:0]  smg_q;
    logic [2:0]  scan_q;
    logic        frame_done_q;

    logic        slot_end;
    logic [3:0]  digit_nib;
    logic        digit_blank;
    logic [2:0]  scan_n;
    logic [7:0]  lit_data;

    function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'h86;
        endcase
        return seg;
    endfunction

    assign slot_end = (C1 == T1MS);

    // Blanking only looks at zero nibbles; an invalid nibble is never zero, so it always shows 'E'.
    always_comb begin
        digit_nib   = rNum[3:0];
        digit_blank = 1'b0;
        scan_n      = 3'b111;
        case (state)
            DIG0: begin
                digit_nib = rNum[3:0];
                scan_n    = 3'b110;
            end
            DIG1: begin
                digit_nib   = rNum[7:4];
                digit_blank = rBlank && (rNum[11:8] == 4'd0) && (rNum[7:4] == 4'd0);
                scan_n      = 3'b101;
            end
            DIG2: begin
                digit_nib   = rNum[11:8];
                digit_blank = rBlank && (rNum[11:8] == 4'd0);
                scan_n      = 3'b011;
            end
            default: ;
        endcase
    end

    assign lit_data = digit_blank ? 8'hFF : seg7_decode(digit_nib);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            C1           <= 16'd0;
            state        <= DIG0;
            rNum         <= 12'd0;
            rBlank       <= 1'b0;
            smg_q        <= 8'hFF;
            scan_q       <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            C1 <= slot_end ? 16'd0 : C1 + 16'd1;

            case (state)
                DIG0: if (slot_end) state <= DIG1;
                DIG1: if (slot_end) state <= DIG2;
                DIG2: begin
                    if (slot_end) begin
                        state  <= DIG0;
                        rNum   <= bus.Number_Sig;
                        rBlank <= bus.Blank_En;
                    end
                end
                default: state <= DIG0;
            endcase

            frame_done_q <= slot_end && (state == DIG2);

            // Outputs lag C1 by one cycle: they reflect the slot position just counted.
            if (C1 < DEAD) begin
                smg_q  <= 8'hFF;
                scan_q <= 3'b111;
            end else begin
                smg_q  <= lit_data;
                scan_q <= scan_n;
            end
        end
    end

    assign bus.SMG_Data   = smg_q;
    assign bus.Scan_Sig   = scan_q;
    assign bus.Frame_Done = frame_done_q;
    assign bus.Scan_State = state;
endmodule
